// File: rtl/sq_packer.sv
// sq_packer: packs a 45-entry code-length table into literal words plus escape/length pairs for zero runs.
// Optional macro SQ_PACKER_ERRCHK_EN turns entries above 8 into literal 8 and raises the sticky err flag.
module sq_packer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [8:0] buff_addr,
  output logic       buff_rd_en,
  input  logic [4:0] buff_data,
  output logic [4:0] data_out,
  output logic       data_out_vld,
  input  logic       data_out_rdy,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] FETCH     = 3'd1;
  localparam logic [2:0] SCAN      = 3'd2;
  localparam logic [2:0] EMIT_ESC  = 3'd3;
  localparam logic [2:0] EMIT_CNT  = 3'd4;
  localparam logic [2:0] EMIT_ZERO = 3'd5;
  localparam logic [2:0] EMIT_LIT  = 3'd6;
  localparam logic [2:0] FIN       = 3'd7;

  localparam logic [5:0] LAST_IDX = 6'd44;

  logic [2:0] state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [4:0] run_q, run_d;
  logic [4:0] data_q, data_d;
  logic [4:0] cnt_q, cnt_d;
  logic [4:0] lit_q, lit_d;
  logic       lit_pend_q, lit_pend_d;
  logic       last_q, last_d;
  logic       err_q, err_d;

  logic       xfer;
  logic       do_close;
  logic       run_done;
  logic       advance;
  logic [4:0] close_len;
  logic [4:0] run_inc;
  logic [4:0] lit_val;

  assign xfer = data_out_vld & data_out_rdy;

  // idx_q always points at the next entry to read once SCAN is left, so EMIT_* states
  // can issue that read in the same cycle their last word transfers.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    run_d      = run_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    lit_d      = lit_q;
    lit_pend_d = lit_pend_q;
    last_d     = last_q;
    err_d      = err_q;
    buff_rd_en = 1'b0;
    do_close   = 1'b0;
    close_len  = run_q;
    run_done   = 1'b0;
    advance    = 1'b0;
    run_inc    = run_q + 5'd1;
`ifdef SQ_PACKER_ERRCHK_EN
    lit_val    = (buff_data > 5'd8) ? 5'd8 : buff_data;
`else
    lit_val    = buff_data;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = FETCH;
          idx_d      = 6'd0;
          run_d      = 5'd0;
          lit_pend_d = 1'b0;
          last_d     = 1'b0;
          err_d      = 1'b0;
        end
      end
      FETCH: begin
        buff_rd_en = 1'b1;
        state_d    = SCAN;
      end
      SCAN: begin
        last_d = (idx_q == LAST_IDX);
        if (idx_q != LAST_IDX) begin
          idx_d = idx_q + 6'd1;
        end
        if (buff_data == 5'd0) begin
          if ((run_inc == 5'd31) || (idx_q == LAST_IDX)) begin
            do_close  = 1'b1;
            close_len = run_inc;
          end else begin
            run_d   = run_inc;
            state_d = FETCH;
          end
        end else begin
          lit_d = lit_val;
`ifdef SQ_PACKER_ERRCHK_EN
          if (buff_data > 5'd8) begin
            err_d = 1'b1;
          end
`endif
          if (run_q != 5'd0) begin
            do_close   = 1'b1;
            lit_pend_d = 1'b1;
          end else begin
            data_d  = lit_val;
            state_d = EMIT_LIT;
          end
        end
      end
      EMIT_ESC: begin
        if (xfer) begin
          data_d  = cnt_q;
          state_d = EMIT_CNT;
        end
      end
      EMIT_CNT: begin
        if (xfer) begin
          run_done = 1'b1;
        end
      end
      EMIT_ZERO: begin
        if (xfer) begin
          if (cnt_q != 5'd0) begin
            cnt_d = cnt_q - 5'd1;
          end else begin
            run_done = 1'b1;
          end
        end
      end
      EMIT_LIT: begin
        if (xfer) begin
          advance = 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A closing run is at least one zero long; short runs go out as plain zeros.
    if (do_close) begin
      run_d = 5'd0;
      if (close_len >= 5'd3) begin
        data_d  = 5'd9;
        cnt_d   = close_len - 5'd3;
        state_d = EMIT_ESC;
      end else begin
        data_d  = 5'd0;
        cnt_d   = close_len - 5'd1;
        state_d = EMIT_ZERO;
      end
    end

    if (run_done) begin
      if (lit_pend_q) begin
        lit_pend_d = 1'b0;
        data_d     = lit_q;
        state_d    = EMIT_LIT;
      end else begin
        advance = 1'b1;
      end
    end

    if (advance) begin
      if (last_q) begin
        state_d = FIN;
      end else begin
        buff_rd_en = 1'b1;
        state_d    = SCAN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= 6'd0;
      run_q      <= 5'd0;
      data_q     <= 5'd0;
      cnt_q      <= 5'd0;
      lit_q      <= 5'd0;
      lit_pend_q <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      run_q      <= run_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      lit_q      <= lit_d;
      lit_pend_q <= lit_pend_d;
      last_q     <= last_d;
      err_q      <= err_d;
    end
  end

  assign buff_addr    = {3'b000, idx_q};
  assign data_out     = data_q;
  assign data_out_vld = (state_q == EMIT_ESC) || (state_q == EMIT_CNT) ||
                        (state_q == EMIT_ZERO) || (state_q == EMIT_LIT);
  assign busy         = (state_q != IDLE) && (state_q != FIN);
  assign done         = (state_q == FIN);
  assign err          = err_q;

endmodule
